img_seq_ctrl: RTL and testbench

Parametrised, programmable successor to the fixed-program control unit of the image datapath. Holds a writable instruction memory of coordinate/channel operations and sequences through it with an FSM. Issues each operation to the ULA over a valid/ready handshake and waits for the ULA result. Registers the result with its bounds-checked linear frame-buffer address.

---
 rtl/img_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_img_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_seq_ctrl.sv
// img_seq_ctrl: programmable sequencer that issues {ch, y, x} operations to the ULA and registers each result with its frame-buffer address.
// Build option COORD_CLAMP_EN: out-of-bounds result coordinates are clamped to the image edge for address generation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | program memory writable, waiting for start
// S_FETCH | read mem[pc], decode HALT or load operation registers
// S_ISSUE | op_valid high, operation held until op_ready
// S_WAIT  | waiting for ULA res_valid, then advance pc or finish
// S_DONE  | one-cycle done pulse, return to idle
module img_seq_ctrl #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int COORD_W    = 10,
    parameter int PIX_W      = 8,
    parameter int CH_W       = 3,
    parameter int ADDR_W     = 17,
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        prog_we,
    input  logic [PC_W-1:0]             prog_addr,
    input  logic [CH_W+2*COORD_W-1:0]   prog_data,
    output logic [PC_W-1:0]             pc,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic [COORD_W-1:0]          next_x,
    output logic [COORD_W-1:0]          next_y,
    output logic [CH_W-1:0]             ch,
    input  logic                        res_valid,
    input  logic [COORD_W-1:0]          img_x_in,
    input  logic [COORD_W-1:0]          img_y_in,
    input  logic [PIX_W-1:0]            pixel_in,
    output logic                        out_valid,
    output logic [ADDR_W-1:0]           address,
    output logic [COORD_W-1:0]          img_x,
    output logic [COORD_W-1:0]          img_y,
    output logic [PIX_W-1:0]            pixel_out,
    output logic                        oob
);
    localparam int INSTR_W = CH_W + 2*COORD_W;
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  mem [PROG_DEPTH];
    logic [INSTR_W-1:0]  instr;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [COORD_W-1:0]  nx_q, nx_d, ny_q, ny_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                res_acc;

    logic                out_valid_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COORD_W-1:0]  img_x_q, img_y_q;
    logic [PIX_W-1:0]    pix_q;
    logic                oob_q;
    logic                in_x, in_y;
    logic [COORD_W-1:0]  x_eff, y_eff;

    assign instr = mem[pc_q];

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && prog_we)
            mem[prog_addr] <= prog_data;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        ch_d    = ch_q;
        res_acc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (&instr[INSTR_W-1 -: CH_W]) begin
                    state_d = S_DONE;
                end else begin
                    nx_d    = instr[COORD_W-1:0];
                    ny_d    = instr[2*COORD_W-1:COORD_W];
                    ch_d    = instr[INSTR_W-1 -: CH_W];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid) begin
                    res_acc = 1'b1;
                    if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address arithmetic is done modulo 2^ADDR_W, identical to a full-width product truncated afterwards.
    assign in_x = (32'(img_x_in) < IMG_W);
    assign in_y = (32'(img_y_in) < IMG_H);
`ifdef COORD_CLAMP_EN
    assign x_eff  = in_x ? img_x_in : COORD_W'(IMG_W - 1);
    assign y_eff  = in_y ? img_y_in : COORD_W'(IMG_H - 1);
    assign addr_d = ADDR_W'(y_eff) * ADDR_W'(IMG_W) + ADDR_W'(x_eff);
`else
    assign x_eff  = img_x_in;
    assign y_eff  = img_y_in;
    assign addr_d = (in_x && in_y) ? ADDR_W'(y_eff) * ADDR_W'(IMG_W) + ADDR_W'(x_eff) : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            img_x_q     <= '0;
            img_y_q     <= '0;
            pix_q       <= '0;
            oob_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            ch_q        <= ch_d;
            out_valid_q <= res_acc;
            if (res_acc) begin
                addr_q  <= addr_d;
                img_x_q <= img_x_in;
                img_y_q <= img_y_in;
                pix_q   <= pixel_in;
                oob_q   <= !(in_x && in_y);
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign op_valid  = (state_q == S_ISSUE);
    assign pc        = pc_q;
    assign next_x    = nx_q;
    assign next_y    = ny_q;
    assign ch        = ch_q;
    assign out_valid = out_valid_q;
    assign address   = addr_q;
    assign img_x     = img_x_q;
    assign img_y     = img_y_q;
    assign pixel_out = pix_q;
    assign oob       = oob_q;
endmodule

// File: tb/tb_img_seq_ctrl.sv
// Testbench for img_seq_ctrl: directed programs plus randomized ULA timing/results, checked against an array/queue reference model.
module tb_img_seq_ctrl;
    localparam int IMG_W      = 320;
    localparam int IMG_H      = 240;
    localparam int COORD_W    = 10;
    localparam int PIX_W      = 8;
    localparam int CH_W       = 3;
    localparam int ADDR_W     = 17;
    localparam int PROG_DEPTH = 16;
    localparam int PC_W       = 4;
    localparam int INSTR_W    = CH_W + 2*COORD_W;
    localparam int HALT       = (1 << CH_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst, start, prog_we, op_ready, res_valid;
    logic [PC_W-1:0]      prog_addr;
    logic [INSTR_W-1:0]   prog_data;
    logic [COORD_W-1:0]   img_x_in, img_y_in;
    logic [PIX_W-1:0]     pixel_in;
    logic                 busy, done, op_valid, out_valid, oob;
    logic [PC_W-1:0]      pc;
    logic [COORD_W-1:0]   next_x, next_y, img_x, img_y;
    logic [CH_W-1:0]      ch;
    logic [ADDR_W-1:0]    address;
    logic [PIX_W-1:0]     pixel_out;

    img_seq_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .PIX_W(PIX_W),
        .CH_W(CH_W), .ADDR_W(ADDR_W), .PROG_DEPTH(PROG_DEPTH), .PC_W(PC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .pc(pc),
        .op_valid(op_valid), .op_ready(op_ready), .next_x(next_x), .next_y(next_y), .ch(ch),
        .res_valid(res_valid), .img_x_in(img_x_in), .img_y_in(img_y_in), .pixel_in(pixel_in),
        .out_valid(out_valid), .address(address), .img_x(img_x), .img_y(img_y),
        .pixel_out(pixel_out), .oob(oob)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int pix; int addr; bit oob; } res_t;

    res_t exp_q[$];
    int   mx[PROG_DEPTH];
    int   my[PROG_DEPTH];
    int   mch[PROG_DEPTH];
    int   n_pass   = 0;
    int   n_checks = 0;
    int   fix_pix  = -1;
    int   force_rdy = -1;
    bit   rnd  = 1'b0;
    bit   junk = 1'b0;
    bit   echo = 1'b1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: linear address of a result coordinate, per the bounds/clamp rules.
    function automatic res_t model_res(input int x, input int y, input int p);
        res_t r;
        int cx, cy;
        r.x = x; r.y = y; r.pix = p;
        r.oob = !(x < IMG_W && y < IMG_H);
        cx = (x < IMG_W) ? x : IMG_W - 1;
        cy = (y < IMG_H) ? y : IMG_H - 1;
`ifdef COORD_CLAMP_EN
        r.addr = (cy * IMG_W + cx) % (1 << ADDR_W);
`else
        r.addr = r.oob ? 0 : (y * IMG_W + x) % (1 << ADDR_W);
`endif
        return r;
    endfunction

    function automatic int pick_delay(input bit for_ready);
        if (for_ready && force_rdy >= 0) return force_rdy;
        return rnd ? int'($urandom_range(0, 3)) : 0;
    endfunction

    task automatic prog(input int a, input int c, input int y, input int x);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = PC_W'(a);
        prog_data = {c[CH_W-1:0], y[COORD_W-1:0], x[COORD_W-1:0]};
        @(negedge clk);
        prog_we = 1'b0;
        mch[a] = c; my[a] = y; mx[a] = x;
    endtask

    task automatic clear_inputs();
        start = 0; prog_we = 0; op_ready = 0; res_valid = 0;
    endtask

    task automatic run_prog();
        int   n_ops = PROG_DEPTH;
        int   n_res = 0, cur = 0, phase = 0, wcnt = 0, dly, rx, ry, rp, k;
        bit   seen_done = 1'b0;
        res_t r;
        for (int i = PROG_DEPTH - 1; i >= 0; i--)
            if (mch[i] == HALT) n_ops = i;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        dly = pick_delay(1'b1);
        for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
                else begin
                    r = exp_q.pop_front();
                    chk("address", address, r.addr);
                    chk("oob", oob, r.oob);
                    chk("img_x", img_x, r.x);
                    chk("img_y", img_y, r.y);
                    chk("pixel_out", pixel_out, r.pix);
                    n_res++;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_pc", pc, (n_ops == PROG_DEPTH) ? PROG_DEPTH - 1 : n_ops);
                chk("result_count", n_res, n_ops);
                chk("ops_issued", cur, n_ops);
            end else begin
                clear_inputs();
                if (phase == 1) begin phase = 2; dly = pick_delay(1'b0); wcnt = 0; end
                if (phase == 2) begin
                    if (wcnt >= dly) begin
                        k  = (cur < PROG_DEPTH) ? cur : 0;
                        if (echo) begin rx = mx[k]; ry = my[k]; end
                        else begin
                            rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, IMG_W - 1));
                            ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, IMG_H - 1));
                        end
                        rp = (fix_pix >= 0) ? fix_pix : int'($urandom_range(0, 255));
                        res_valid = 1'b1;
                        img_x_in  = COORD_W'(rx);
                        img_y_in  = COORD_W'(ry);
                        pixel_in  = PIX_W'(rp);
                        exp_q.push_back(model_res(rx, ry, rp));
                        cur++;
                        phase = 0; wcnt = 0; dly = pick_delay(1'b1);
                    end else begin
                        wcnt++;
                        if (junk) begin
                            start     = ($urandom_range(0, 2) == 0);
                            prog_we   = ($urandom_range(0, 2) == 0);
                            prog_addr = PC_W'($urandom);
                            prog_data = INSTR_W'($urandom);
                        end
                    end
                end else if (op_valid) begin
                    k = (cur < PROG_DEPTH) ? cur : 0;
                    chk("op_pc", pc, cur);
                    chk("op_x", next_x, mx[k]);
                    chk("op_y", next_y, my[k]);
                    chk("op_ch", ch, mch[k]);
                    if (wcnt >= dly) begin op_ready = 1'b1; phase = 1; wcnt = 0; end
                    else wcnt++;
                    if (junk) begin
                        res_valid = $urandom_range(0, 1) == 1;
                        img_x_in  = COORD_W'($urandom);
                        img_y_in  = COORD_W'($urandom);
                    end
                end
                @(negedge clk);
            end
        end
        clear_inputs();
        if (!seen_done) chk("run_timeout", 0, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        chk("pending_results", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        rst = 1'b1; clear_inputs();
        prog_addr = '0; prog_data = '0;
        img_x_in = '0; img_y_in = '0; pixel_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_address", address, 0);
        chk("rst_oob", oob, 0);
        rst = 1'b0;

        // Basic program with immediate handshakes and echoed coordinates.
        prog(0, 0, 60, 50); prog(1, 2, 80, 100); prog(2, 4, 120, 150); prog(3, HALT, 0, 0);
        run_prog();

        // Boundary coordinates with a fixed pixel value.
        prog(0, 1, 239, 319); prog(1, 1, 10, 320); prog(2, HALT, 0, 0);
        fix_pix = 8'hA5;
        run_prog();
        fix_pix = -1;

        // Ready withheld for 5 cycles on every operation.
        force_rdy = 5;
        run_prog();
        force_rdy = -1;

        // Full 16-entry random programs with random ULA timing, random results and ignored stimulus.
        rnd = 1'b1; echo = 1'b0;
        for (int it = 0; it < 3; it++) begin
            for (int a = 0; a < PROG_DEPTH; a++)
                prog(a, $urandom_range(0, HALT - 1), $urandom_range(0, 1023), $urandom_range(0, 1023));
            junk = 1'b1;
            run_prog();
            junk = 1'b0;
            res_valid = 1'b1; img_x_in = 10'd3; img_y_in = 10'd4;
            @(negedge clk); chk("idle_res_valid_1", out_valid, 0);
            @(negedge clk); chk("idle_res_valid_2", out_valid, 0);
            res_valid = 1'b0;
            run_prog();
        end

        // Reset while waiting on a result, then rerun from entry 0.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (!op_valid && cnt < 10) begin @(negedge clk); cnt++; end
        chk("rst_test_issue", op_valid, 1);
        op_ready = 1'b1;
        @(negedge clk); op_ready = 1'b0;
        chk("rst_test_in_wait", busy, 1);
        rst = 1'b1; res_valid = 1'b1; img_x_in = 10'd7; img_y_in = 10'd7; pixel_in = 8'h11;
        @(negedge clk);
        rst = 1'b0; res_valid = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_op_valid", op_valid, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_next_x", next_x, 0);
        chk("mid_rst_ch", ch, 0);
        chk("mid_rst_address", address, 0);
        chk("mid_rst_img_x", img_x, 0);
        chk("mid_rst_pixel", pixel_out, 0);
        chk("mid_rst_oob", oob, 0);
        @(negedge clk);
        chk("mid_rst_no_late_result", out_valid, 0);
        run_prog();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
